traffic_ctrl: RTL and testbench

Parametrised two-way traffic-light controller with timed green/yellow/all-red phases, per-way two-digit countdown on active-low 7-segment displays, and a manual hold/advance mode. It drives the board GPIO lights and the HEX displays directly from `clk`. It extends the fixed 4-state, 3-second, single-digit controller with configurable durations, an optional all-red clearance phase, a built-in seconds divider and a synchronised operator input.

---
 rtl/traffic_pkg.sv | 48 ++++
 rtl/seg7_dec.sv | 14 +
 rtl/traffic_ctrl.sv | 122 ++++++++++++
 tb/tb_traffic_ctrl.sv | 225 ++++++++++++++++++++++
 4 files changed

// File: rtl/traffic_pkg.sv
// rtl/traffic_pkg.sv - phase type, segment constants and helpers for traffic_ctrl
package traffic_pkg;

    typedef enum logic [2:0] {G0, Y0, R0, G1, Y1, R1} phase_t;

    // Active-low segments, bit order gfedcba
    localparam logic [6:0] SEG_DIGIT [0:9] = '{
        7'h40, 7'h79, 7'h24, 7'h30, 7'h19,
        7'h12, 7'h02, 7'h78, 7'h00, 7'h10
    };
    localparam logic [6:0] SEG_BLANK = 7'h7F;

    function automatic phase_t next_phase(phase_t p, logic clearance);
        case (p)
            G0:      return Y0;
            Y0:      return clearance ? R0 : G1;
            R0:      return G1;
            G1:      return Y1;
            Y1:      return clearance ? R1 : G0;
            default: return G0;
        endcase
    endfunction

    // Lamp vector {r0, y0, g0, r1, y1, g1}
    function automatic logic [5:0] lamps_of(phase_t p);
        case (p)
            G0:      return 6'b001_100;
            Y0:      return 6'b010_100;
            G1:      return 6'b100_001;
            Y1:      return 6'b100_010;
            default: return 6'b100_100;
        endcase
    endfunction

    // Restoring compare-subtract split into {tens, units}; valid for v < 160
    function automatic logic [7:0] to_digits(logic [6:0] v);
        logic [6:0] r;
        logic [3:0] t;
        r = v;
        t = '0;
        if (r >= 7'd80) begin t[3] = 1'b1; r = r - 7'd80; end
        if (r >= 7'd40) begin t[2] = 1'b1; r = r - 7'd40; end
        if (r >= 7'd20) begin t[1] = 1'b1; r = r - 7'd20; end
        if (r >= 7'd10) begin t[0] = 1'b1; r = r - 7'd10; end
        return {t, r[3:0]};
    endfunction

endpackage

// File: rtl/seg7_dec.sv
// rtl/seg7_dec.sv - 4-bit digit to active-low 7-segment decoder
module seg7_dec
    import traffic_pkg::*;
(
    input  logic [3:0] digit,
    output logic [6:0] seg
);

    always_comb begin
        seg = SEG_BLANK;
        if (digit <= 4'd9) seg = SEG_DIGIT[digit];
    end

endmodule

// File: rtl/traffic_ctrl.sv
// rtl/traffic_ctrl.sv - two-way timed traffic light controller with countdown displays
module traffic_ctrl
    import traffic_pkg::*;
#(
    parameter int TICK_DIV = 50_000_000,
    parameter int GREEN_S  = 9,
    parameter int YELLOW_S = 3,
    parameter int ALLRED_S = 1
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       manual,
    input  logic       adv,
    output logic       rled0,
    output logic       yled0,
    output logic       gled0,
    output logic       rled1,
    output logic       yled1,
    output logic       gled1,
    output logic [6:0] hex0_t,
    output logic [6:0] hex0_u,
    output logic [6:0] hex1_t,
    output logic [6:0] hex1_u
);

    localparam int             DW       = (TICK_DIV > 2) ? $clog2(TICK_DIV) : 1;
    localparam logic [DW-1:0]  DIV_LAST = DW'(TICK_DIV - 1);
    localparam logic [6:0]     G_D      = 7'(GREEN_S);
    localparam logic [6:0]     Y_D      = 7'(YELLOW_S);
    localparam logic [6:0]     A_D      = 7'(ALLRED_S);
    localparam logic           CLEAR    = (ALLRED_S != 0);

    if (TICK_DIV < 2 || GREEN_S < 1 || YELLOW_S < 1 || ALLRED_S < 0 ||
        GREEN_S + YELLOW_S + ALLRED_S > 99) begin : g_param_check
        $error("traffic_ctrl: invalid timing parameters");
    end

    phase_t        phase;
    logic [6:0]    rem;
    logic [DW-1:0] div;
    logic          adv_s1, adv_s2, adv_q;
    logic [5:0]    lamps;

    logic   tick, hold, adv_rise;
    phase_t nxt, yel;

    function automatic logic [6:0] dur(phase_t p);
        case (p)
            G0, G1:  return G_D;
            Y0, Y1:  return Y_D;
            default: return A_D;
        endcase
    endfunction

    assign tick     = (div == DIV_LAST);
    assign hold     = manual && (phase == G0 || phase == G1);
    assign adv_rise = adv_s2 && !adv_q;
    assign nxt      = next_phase(phase, CLEAR);
    assign yel      = (phase == G1) ? Y1 : Y0;

    // A held green freezes rem and the divider; an adv edge seen outside a hold is dropped
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            phase  <= G0;
            rem    <= G_D;
            div    <= '0;
            adv_s1 <= 1'b0;
            adv_s2 <= 1'b0;
            adv_q  <= 1'b0;
            lamps  <= lamps_of(G0);
        end else begin
            adv_s1 <= adv;
            adv_s2 <= adv_s1;
            adv_q  <= adv_s2;
            if (hold) begin
                if (adv_rise) begin
                    phase <= yel;
                    lamps <= lamps_of(yel);
                    rem   <= Y_D;
                    div   <= '0;
                end
            end else if (tick) begin
                div <= '0;
                if (rem == 7'd1) begin
                    phase <= nxt;
                    lamps <= lamps_of(nxt);
                    rem   <= dur(nxt);
                end else begin
                    rem <= rem - 7'd1;
                end
            end else begin
                div <= div + DW'(1);
            end
        end
    end

    assign {rled0, yled0, gled0, rled1, yled1, gled1} = lamps;

    // Red way shows time until its own green starts
    logic [6:0] val0, val1;
    always_comb begin
        val0 = rem;
        val1 = rem;
        case (phase)
            G0:      val1 = rem + Y_D + A_D;
            Y0:      val1 = rem + A_D;
            G1:      val0 = rem + Y_D + A_D;
            Y1:      val0 = rem + A_D;
            default: ;
        endcase
    end

    logic [7:0] dig0, dig1;
    assign dig0 = to_digits(val0);
    assign dig1 = to_digits(val1);

    seg7_dec u_hex0_t (.digit(dig0[7:4]), .seg(hex0_t));
    seg7_dec u_hex0_u (.digit(dig0[3:0]), .seg(hex0_u));
    seg7_dec u_hex1_t (.digit(dig1[7:4]), .seg(hex1_t));
    seg7_dec u_hex1_u (.digit(dig1[3:0]), .seg(hex1_u));

endmodule

// File: tb/tb_traffic_ctrl.sv
// tb/tb_traffic_ctrl.sv - self-checking bench for traffic_ctrl
module tb_traffic_ctrl;

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic manual = 1'b0;
    logic adv = 1'b0;
    always #5 clk = ~clk;

    int checks = 0;
    int passed = 0;

    localparam logic [5:0] L_G0 = 6'b001_100;
    localparam logic [5:0] L_Y0 = 6'b010_100;
    localparam logic [5:0] L_RR = 6'b100_100;
    localparam logic [5:0] L_G1 = 6'b100_001;
    localparam logic [5:0] L_Y1 = 6'b100_010;

    logic [6:0] seg_tab [0:9] = '{7'h40, 7'h79, 7'h24, 7'h30, 7'h19,
                                  7'h12, 7'h02, 7'h78, 7'h00, 7'h10};

    typedef struct packed {
        logic [5:0] lamps;
        int         cycles;
    } phase_rec_t;
    phase_rec_t sb[$];

    logic [5:0] lamps_a, lamps_b, lamps_c;
    logic [6:0] h0t_a, h0u_a, h1t_a, h1u_a;
    logic [6:0] h0t_b, h0u_b, h1t_b, h1u_b;
    logic [6:0] h0t_c, h0u_c, h1t_c, h1u_c;

    traffic_ctrl #(.TICK_DIV(4), .GREEN_S(5), .YELLOW_S(2), .ALLRED_S(1)) dut_a (
        .clk(clk), .rst(rst), .manual(manual), .adv(adv),
        .rled0(lamps_a[5]), .yled0(lamps_a[4]), .gled0(lamps_a[3]),
        .rled1(lamps_a[2]), .yled1(lamps_a[1]), .gled1(lamps_a[0]),
        .hex0_t(h0t_a), .hex0_u(h0u_a), .hex1_t(h1t_a), .hex1_u(h1u_a)
    );

    traffic_ctrl #(.TICK_DIV(4), .GREEN_S(5), .YELLOW_S(2), .ALLRED_S(0)) dut_b (
        .clk(clk), .rst(rst), .manual(1'b0), .adv(1'b0),
        .rled0(lamps_b[5]), .yled0(lamps_b[4]), .gled0(lamps_b[3]),
        .rled1(lamps_b[2]), .yled1(lamps_b[1]), .gled1(lamps_b[0]),
        .hex0_t(h0t_b), .hex0_u(h0u_b), .hex1_t(h1t_b), .hex1_u(h1u_b)
    );

    traffic_ctrl #(.TICK_DIV(4), .GREEN_S(95), .YELLOW_S(3), .ALLRED_S(1)) dut_c (
        .clk(clk), .rst(rst), .manual(1'b0), .adv(1'b0),
        .rled0(lamps_c[5]), .yled0(lamps_c[4]), .gled0(lamps_c[3]),
        .rled1(lamps_c[2]), .yled1(lamps_c[1]), .gled1(lamps_c[0]),
        .hex0_t(h0t_c), .hex0_u(h0u_c), .hex1_t(h1t_c), .hex1_u(h1u_c)
    );

    function automatic logic [13:0] show(int v);
        return {seg_tab[v / 10], seg_tab[v % 10]};
    endfunction

    task automatic do_reset();
        @(negedge clk);
        #2 rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
    endtask

    task automatic test_reset();
        int n;
        do_reset();
        repeat (30) @(negedge clk);
        #3 rst = 1'b1;
        #1;
        checks++; if (lamps_a !== L_G0) $display("FAIL reset_lamps: got %b want %b", lamps_a, L_G0); else passed++;
        checks++; if ({h0t_a, h0u_a} !== show(5)) $display("FAIL reset_hex0: got %h want %h", {h0t_a, h0u_a}, show(5)); else passed++;
        checks++; if ({h1t_a, h1u_a} !== show(8)) $display("FAIL reset_hex1: got %h want %h", {h1t_a, h1u_a}, show(8)); else passed++;
        checks++; if ({h0t_c, h0u_c} !== show(95)) $display("FAIL limit_hex0: got %h want %h", {h0t_c, h0u_c}, show(95)); else passed++;
        checks++; if ({h1t_c, h1u_c} !== show(99)) $display("FAIL limit_hex1: got %h want %h", {h1t_c, h1u_c}, show(99)); else passed++;
        @(negedge clk);
        rst = 1'b0;
        n = 0;
        while (lamps_a === L_G0 && n < 40) begin @(negedge clk); n++; end
        checks++; if (n != 20) $display("FAIL reset_g0_len: got %0d want 20", n); else passed++;
    endtask

    task automatic test_display();
        do_reset();
        repeat (9) @(negedge clk);
        checks++; if ({h0t_a, h0u_a} !== show(3)) $display("FAIL disp_hex0: got %h want %h", {h0t_a, h0u_a}, show(3)); else passed++;
        checks++; if ({h1t_a, h1u_a} !== show(6)) $display("FAIL disp_hex1: got %h want %h", {h1t_a, h1u_a}, show(6)); else passed++;
        checks++; if ({h0t_b, h0u_b} !== show(3)) $display("FAIL noclr_hex0: got %h want %h", {h0t_b, h0u_b}, show(3)); else passed++;
        checks++; if ({h1t_b, h1u_b} !== show(5)) $display("FAIL noclr_hex1: got %h want %h", {h1t_b, h1u_b}, show(5)); else passed++;
    endtask

    task automatic test_auto_cycle();
        phase_rec_t rec;
        logic [5:0] cur;
        int cnt, period, guard;
        do_reset();
        sb.delete();
        repeat (2) begin
            sb.push_back('{L_G0, 20}); sb.push_back('{L_Y0, 8}); sb.push_back('{L_RR, 4});
            sb.push_back('{L_G1, 20}); sb.push_back('{L_Y1, 8}); sb.push_back('{L_RR, 4});
        end
        cur = lamps_a; cnt = 1; period = 0; guard = 0;
        while (sb.size() > 0 && guard < 400) begin
            @(negedge clk); guard++;
            if (lamps_a === cur) cnt++;
            else begin
                rec = sb.pop_front();
                checks++;
                if (cur !== rec.lamps || cnt != rec.cycles)
                    $display("FAIL auto_phase: got %b x%0d want %b x%0d", cur, cnt, rec.lamps, rec.cycles);
                else passed++;
                period += cnt;
                cur = lamps_a; cnt = 1;
            end
        end
        checks++; if (sb.size() != 0) $display("FAIL auto_timeout: %0d phases left want 0", sb.size()); else passed++;
        checks++; if (period != 128) $display("FAIL auto_period: got %0d want 128", period); else passed++;
    endtask

    task automatic test_no_clearance();
        phase_rec_t rec;
        logic [5:0] cur;
        int cnt, period, guard;
        do_reset();
        sb.delete();
        sb.push_back('{L_G0, 20}); sb.push_back('{L_Y0, 8});
        sb.push_back('{L_G1, 20}); sb.push_back('{L_Y1, 8});
        cur = lamps_b; cnt = 1; period = 0; guard = 0;
        while (sb.size() > 0 && guard < 200) begin
            @(negedge clk); guard++;
            if (lamps_b === cur) cnt++;
            else begin
                rec = sb.pop_front();
                checks++;
                if (cur !== rec.lamps || cnt != rec.cycles)
                    $display("FAIL noclr_phase: got %b x%0d want %b x%0d", cur, cnt, rec.lamps, rec.cycles);
                else passed++;
                period += cnt;
                cur = lamps_b; cnt = 1;
            end
        end
        checks++; if (sb.size() != 0) $display("FAIL noclr_timeout: %0d phases left want 0", sb.size()); else passed++;
        checks++; if (period != 56) $display("FAIL noclr_period: got %0d want 56", period); else passed++;
    endtask

    task automatic test_manual_hold();
        int cnt;
        do_reset();
        repeat (8) @(negedge clk);
        manual = 1'b1;
        repeat (100) @(negedge clk);
        checks++; if ({h0t_a, h0u_a} !== show(3)) $display("FAIL hold_rem: got %h want %h", {h0t_a, h0u_a}, show(3)); else passed++;
        adv = 1'b1;
        repeat (2) @(negedge clk);
        checks++; if (lamps_a !== L_G0) $display("FAIL adv_edge2: got %b want %b", lamps_a, L_G0); else passed++;
        @(negedge clk);
        checks++; if (lamps_a !== L_Y0) $display("FAIL adv_edge3: got %b want %b", lamps_a, L_Y0); else passed++;
        checks++; if ({h0t_a, h0u_a} !== show(2)) $display("FAIL adv_rem: got %h want %h", {h0t_a, h0u_a}, show(2)); else passed++;
        checks++; if ({h1t_a, h1u_a} !== show(3)) $display("FAIL adv_hex1: got %h want %h", {h1t_a, h1u_a}, show(3)); else passed++;
        cnt = 1;
        while (lamps_a === L_Y0 && cnt < 40) begin
            @(negedge clk);
            if (cnt == 1) adv = 1'b0;
            if (cnt == 3) adv = 1'b1;
            if (lamps_a === L_Y0) cnt++;
        end
        checks++; if (cnt != 8) $display("FAIL y0_adv_ignored: got %0d want 8", cnt); else passed++;
        checks++; if (lamps_a !== L_RR) $display("FAIL after_y0: got %b want %b", lamps_a, L_RR); else passed++;
        manual = 1'b0;
        adv = 1'b0;
    endtask

    task automatic test_resume();
        int n;
        do_reset();
        repeat (8) @(negedge clk);
        manual = 1'b1;
        repeat (50) @(negedge clk);
        checks++; if (lamps_a !== L_G0) $display("FAIL resume_held: got %b want %b", lamps_a, L_G0); else passed++;
        manual = 1'b0;
        n = 0;
        while (lamps_a === L_G0 && n < 40) begin @(negedge clk); n++; end
        checks++; if (n != 12) $display("FAIL resume_len: got %0d want 12", n); else passed++;
    endtask

    task automatic test_mid_reset();
        int n;
        do_reset();
        n = 0;
        while (lamps_a !== L_Y1 && n < 200) begin @(negedge clk); n++; end
        repeat (4) @(negedge clk);
        checks++; if ({h1t_a, h1u_a} !== show(1)) $display("FAIL y1_rem1: got %h want %h", {h1t_a, h1u_a}, show(1)); else passed++;
        #3 rst = 1'b1;
        #1;
        checks++; if (lamps_a !== L_G0) $display("FAIL mid_rst_lamps: got %b want %b", lamps_a, L_G0); else passed++;
        checks++; if ({h0t_a, h0u_a} !== show(5)) $display("FAIL mid_rst_hex0: got %h want %h", {h0t_a, h0u_a}, show(5)); else passed++;
        checks++; if ({h1t_a, h1u_a} !== show(8)) $display("FAIL mid_rst_hex1: got %h want %h", {h1t_a, h1u_a}, show(8)); else passed++;
        @(negedge clk);
        rst = 1'b0;
        n = 0;
        while (lamps_a === L_G0 && n < 40) begin @(negedge clk); n++; end
        checks++; if (n != 20) $display("FAIL mid_rst_g0_len: got %0d want 20", n); else passed++;
    endtask

    initial begin
        repeat (2) @(negedge clk);
        rst = 1'b0;
        test_reset();
        test_display();
        test_auto_cycle();
        test_no_clearance();
        test_manual_hold();
        test_resume();
        test_mid_reset();
        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not complete, %0d/%0d so far", passed, checks);
        $fatal(1);
    end

endmodule
